// File: rtl/rv_test_monitor.sv
// rtl/rv_test_monitor.sv - core reset sequencer and pass/fail/timeout/hang result monitor
// Holds the core in reset, then watches tohost stores and PC progress until a verdict is reached.
module rv_test_monitor #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] TOHOST_ADDR  = 32'h0000_00FC,
  parameter int               RESET_CYCLES = 4,
  parameter int               TIMEOUT      = 100000,
  parameter int               STALL_LIMIT  = 16,
  parameter int               CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] Address,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             MemWrite,
  output logic             core_reset,
  output logic             done,
  output logic             pass,
  output logic [2:0]       status,
  output logic [WIDTH-1:0] fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] store_count
);

  localparam int HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST    = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_MAX    = STALL_W'(STALL_LIMIT);
  // 64-bit compare lets a counter narrower than TIMEOUT simply never match.
  localparam logic [63:0]        TIMEOUT_LAST = 64'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4,
    S_HANG    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   store_q, store_d;
  logic [WIDTH-1:0]   prev_pc_q, prev_pc_d;
  logic [WIDTH-1:0]   fail_code_q, fail_code_d;
  logic               first_q, first_d;
  logic               core_reset_q, core_reset_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               tohost;

  assign tohost = MemWrite && (Address == TOHOST_ADDR);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    stall_d     = stall_q;
    cycle_d     = cycle_q;
    store_d     = store_q;
    prev_pc_d   = prev_pc_q;
    fail_code_d = fail_code_q;
    first_d     = first_q;
    case (state_q)
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
          hold_d  = '0;
          first_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_RUN: begin
        cycle_d   = (cycle_q == '1) ? cycle_q : cycle_q + CNT_W'(1);
        if (MemWrite && store_q != '1) store_d = store_q + CNT_W'(1);
        prev_pc_d = PC;
        first_d   = 1'b0;
        // prev_pc is meaningless on the first RUN cycle, so no stall is counted there.
        if (!first_q && PC == prev_pc_q && !MemWrite) stall_d = stall_q + STALL_W'(1);
        else stall_d = '0;
        if (tohost && WriteData == WIDTH'(1)) begin
          state_d = S_PASS;
        end else if (tohost && WriteData != '0) begin
          state_d     = S_FAIL;
          fail_code_d = WriteData;
        end else if (64'(cycle_q) == TIMEOUT_LAST) begin
          state_d = S_TIMEOUT;
        end else if (stall_d == STALL_MAX) begin
          state_d = S_HANG;
        end
      end
      default: ;
    endcase
    core_reset_d = (state_d != S_RUN);
    done_d       = (state_d != S_HOLD) && (state_d != S_RUN);
    pass_d       = (state_d == S_PASS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_HOLD;
      hold_q       <= '0;
      stall_q      <= '0;
      cycle_q      <= '0;
      store_q      <= '0;
      prev_pc_q    <= '0;
      fail_code_q  <= '0;
      first_q      <= 1'b0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      stall_q      <= stall_d;
      cycle_q      <= cycle_d;
      store_q      <= store_d;
      prev_pc_q    <= prev_pc_d;
      fail_code_q  <= fail_code_d;
      first_q      <= first_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign status      = state_q;
  assign core_reset  = core_reset_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cycle_q;
  assign store_count = store_q;

endmodule

// File: tb/tb_rv_test_monitor.sv
// tb/tb_rv_test_monitor.sv - directed bench for rv_test_monitor
// u_dut uses default parameters; u_to shares stimulus with TIMEOUT=20.
module tb_rv_test_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] PC = '0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;

  logic        core_reset, done, pass;
  logic [2:0]  status;
  logic [31:0] fail_code, cycle_count, store_count;
  logic        t_core_reset, t_done, t_pass;
  logic [2:0]  t_status;
  logic [31:0] t_fail_code, t_cycle_count, t_store_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_test_monitor u_dut (
    .clk(clk), .reset(reset), .PC(PC), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .core_reset(core_reset), .done(done), .pass(pass),
    .status(status), .fail_code(fail_code), .cycle_count(cycle_count),
    .store_count(store_count)
  );

  rv_test_monitor #(.TIMEOUT(20)) u_to (
    .clk(clk), .reset(reset), .PC(PC), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .core_reset(t_core_reset), .done(t_done), .pass(t_pass),
    .status(t_status), .fail_code(t_fail_code), .cycle_count(t_cycle_count),
    .store_count(t_store_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mw, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] pc);
    MemWrite  = mw;
    Address   = addr;
    WriteData = data;
    PC        = pc;
    step();
    MemWrite  = 1'b0;
  endtask

  task automatic enter_run(input logic [31:0] pc);
    reset    = 1'b1;
    MemWrite = 1'b0;
    PC       = pc;
    step();
    reset = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({status, core_reset, done, pass} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_flags got st=%0d cr=%0b d=%0b p=%0b exp st=0 cr=1 d=0 p=0",
               status, core_reset, done, pass);
    end
    checks++;
    if ({fail_code, cycle_count, store_count} !== 96'd0) begin
      failures++;
      $display("FAIL reset_values got fc=%0h cyc=%0d st=%0d exp 0 0 0",
               fail_code, cycle_count, store_count);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (core_reset !== 1'b1 || status !== 3'd0) begin
        failures++;
        $display("FAIL reset_hold_%0d got cr=%0b st=%0d exp cr=1 st=0", i, core_reset, status);
      end
      step();
    end
    checks++;
    if (core_reset !== 1'b0 || status !== 3'd1 || cycle_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_run_entry got cr=%0b st=%0d cyc=%0d exp cr=0 st=1 cyc=0",
               core_reset, status, cycle_count);
    end
  endtask

  task automatic test_pass();
    enter_run(32'd0);
    for (int i = 0; i < 50; i++)
      drive(i == 10 || i == 20 || i == 30, 32'h100, 32'hAA, 32'(i * 4));
    drive(1'b1, 32'hFC, 32'd1, 32'd200);
    checks++;
    if ({status, done, pass, core_reset} !== {3'd2, 1'b1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL pass_flags got st=%0d d=%0b p=%0b cr=%0b exp st=2 d=1 p=1 cr=1",
               status, done, pass, core_reset);
    end
    checks++;
    if (store_count !== 32'd4 || cycle_count !== 32'd51) begin
      failures++;
      $display("FAIL pass_counts got st=%0d cyc=%0d exp st=4 cyc=51", store_count, cycle_count);
    end
    for (int i = 0; i < 20; i++) drive(i[0], 32'hFC, 32'h5, 32'h300);
    checks++;
    if ({status, pass, cycle_count, store_count, fail_code} !== {3'd2, 1'b1, 32'd51, 32'd4, 32'd0}) begin
      failures++;
      $display("FAIL pass_sticky got st=%0d p=%0b cyc=%0d sc=%0d fc=%0h exp 2 1 51 4 0",
               status, pass, cycle_count, store_count, fail_code);
    end
  endtask

  task automatic test_fail();
    enter_run(32'd0);
    for (int i = 0; i < 5; i++) drive(1'b0, 32'h0, 32'h0, 32'(i * 4));
    drive(1'b1, 32'hFC, 32'h0, 32'd20);
    checks++;
    if (status !== 3'd1 || done !== 1'b0 || store_count !== 32'd1) begin
      failures++;
      $display("FAIL fail_zero_store got st=%0d d=%0b sc=%0d exp st=1 d=0 sc=1",
               status, done, store_count);
    end
    drive(1'b1, 32'hFC, 32'h7, 32'd24);
    checks++;
    if ({status, fail_code, pass, done} !== {3'd3, 32'h7, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL fail_store got st=%0d fc=%0h p=%0b d=%0b exp st=3 fc=7 p=0 d=1",
               status, fail_code, pass, done);
    end
  endtask

  task automatic test_timeout();
    enter_run(32'd0);
    for (int i = 0; i < 19; i++) drive(1'b0, 32'h0, 32'h0, 32'((i / 4) * 4));
    checks++;
    if (t_status !== 3'd1 || t_cycle_count !== 32'd19) begin
      failures++;
      $display("FAIL timeout_before got st=%0d cyc=%0d exp st=1 cyc=19", t_status, t_cycle_count);
    end
    drive(1'b0, 32'h0, 32'h0, 32'd16);
    checks++;
    if ({t_status, t_cycle_count, t_done, t_pass} !== {3'd4, 32'd20, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL timeout_fire got st=%0d cyc=%0d d=%0b p=%0b exp st=4 cyc=20 d=1 p=0",
               t_status, t_cycle_count, t_done, t_pass);
    end
    enter_run(32'd0);
    for (int i = 0; i < 19; i++) drive(1'b0, 32'h0, 32'h0, 32'((i / 4) * 4));
    drive(1'b1, 32'hFC, 32'd1, 32'd16);
    checks++;
    if (t_status !== 3'd2 || t_pass !== 1'b1) begin
      failures++;
      $display("FAIL timeout_vs_pass got st=%0d p=%0b exp st=2 p=1", t_status, t_pass);
    end
  endtask

  task automatic test_hang();
    enter_run(32'h40);
    for (int i = 0; i < 16; i++) drive(1'b0, 32'h0, 32'h0, 32'h40);
    checks++;
    if (status !== 3'd1) begin
      failures++;
      $display("FAIL hang_early got st=%0d exp st=1", status);
    end
    drive(1'b0, 32'h0, 32'h0, 32'h40);
    checks++;
    if (status !== 3'd5 || done !== 1'b1 || core_reset !== 1'b1) begin
      failures++;
      $display("FAIL hang_fire got st=%0d d=%0b cr=%0b exp st=5 d=1 cr=1", status, done, core_reset);
    end
    enter_run(32'h40);
    for (int i = 0; i < 26; i++) drive(i == 10, 32'h100, 32'h0, 32'h40);
    checks++;
    if (status !== 3'd1) begin
      failures++;
      $display("FAIL hang_restart_early got st=%0d exp st=1", status);
    end
    drive(1'b0, 32'h0, 32'h0, 32'h40);
    checks++;
    if (status !== 3'd5) begin
      failures++;
      $display("FAIL hang_restart_fire got st=%0d exp st=5", status);
    end
    enter_run(32'h40);
    for (int i = 0; i < 40; i++) drive(1'b0, 32'h0, 32'h0, 32'(32'h40 + 4 * (i / 8)));
    checks++;
    if (status !== 3'd1 || cycle_count !== 32'd40) begin
      failures++;
      $display("FAIL hang_none got st=%0d cyc=%0d exp st=1 cyc=40", status, cycle_count);
    end
  endtask

  task automatic test_mid_reset();
    enter_run(32'd0);
    for (int i = 0; i < 30; i++) drive(i == 5, 32'h100, 32'h0, 32'(i * 4));
    checks++;
    if (status !== 3'd1 || cycle_count !== 32'd30 || store_count !== 32'd1) begin
      failures++;
      $display("FAIL midrun_pre got st=%0d cyc=%0d sc=%0d exp 1 30 1", status, cycle_count, store_count);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({status, core_reset, done, cycle_count, store_count, fail_code} !==
        {3'd0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL midrun_reset got st=%0d cr=%0b d=%0b cyc=%0d sc=%0d fc=%0h exp 0 1 0 0 0 0",
               status, core_reset, done, cycle_count, store_count, fail_code);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (core_reset !== 1'b1 || status !== 3'd0) begin
        failures++;
        $display("FAIL midrun_hold_%0d got cr=%0b st=%0d exp cr=1 st=0", i, core_reset, status);
      end
      step();
    end
    checks++;
    if (status !== 3'd1 || core_reset !== 1'b0) begin
      failures++;
      $display("FAIL midrun_rerun got st=%0d cr=%0b exp st=1 cr=0", status, core_reset);
    end
    drive(1'b1, 32'hFC, 32'd1, 32'd8);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({status, core_reset, pass, done, cycle_count, store_count} !==
        {3'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL pass_reset got st=%0d cr=%0b p=%0b d=%0b cyc=%0d sc=%0d exp 0 1 0 0 0 0",
               status, core_reset, pass, done, cycle_count, store_count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (core_reset !== 1'b1 || status !== 3'd0) begin
        failures++;
        $display("FAIL pass_hold_%0d got cr=%0b st=%0d exp cr=1 st=0", i, core_reset, status);
      end
      step();
    end
    checks++;
    if (status !== 3'd1) begin
      failures++;
      $display("FAIL pass_rerun got st=%0d exp st=1", status);
    end
    drive(1'b1, 32'hFC, 32'hDEAD, 32'd4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (fail_code !== 32'd0 || status !== 3'd0) begin
      failures++;
      $display("FAIL fail_reset got fc=%0h st=%0d exp fc=0 st=0", fail_code, status);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_hang();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
